// File: rtl/fsm_tbl_ctrl_if.sv
// ---------------------------------------------------------------------------
// fsm_tbl_ctrl_if
// Shadow-bank write port of the transition-table configuration controller.
//
// Handshake: a write transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_addr/cfg_data (and cfg_last when present) are
// qualified by cfg_valid; the master may hold or drop cfg_valid freely since
// cfg_ready does not depend on cfg_valid.
//
// Signals:
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write accepted when high with cfg_valid
//   cfg_addr   master->slave  shadow entry index (AW bits)
//   cfg_data   master->slave  shadow entry value (ENTRY_W bits)
//   cfg_last   master->slave  only with FSM_TBL_CTRL_AUTOCOMMIT_EN: this
//                             accepted write also requests a commit
// ---------------------------------------------------------------------------
interface fsm_tbl_ctrl_if #(
  parameter int AW      = 4,
  parameter int ENTRY_W = 32
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [AW-1:0]      cfg_addr;
  logic [ENTRY_W-1:0] cfg_data;
`ifdef FSM_TBL_CTRL_AUTOCOMMIT_EN
  logic               cfg_last;

  modport master (output cfg_valid, cfg_addr, cfg_data, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, cfg_last, output cfg_ready);
`else
  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
`endif
endinterface

// File: rtl/fsm_tbl_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_tbl_ctrl
// Configuration controller for a table-driven FSM. Keeps an active and a
// shadow bank of transition entries. Writes land in the shadow bank; a commit
// swaps banks once the FSM sits in state 0 (or force_swap is high), then
// holds the FSM in reset for one cycle so it restarts on the new table.
//
// Optional feature macro: FSM_TBL_CTRL_AUTOCOMMIT_EN
//   When defined, an accepted write with cfg_last=1 also acts as a commit.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   cfg            shadow write port (fsm_tbl_ctrl_if.slave)
//   commit         single-cycle swap request (ignored outside IDLE)
//   force_swap     level; while high WAIT_SAFE treats any FSM state as safe
//   fsm_state      current state of the controlled FSM
//   rd_addr        active-bank read index
//   rd_data        active bank[rd_addr], combinational
//   fsm_hold       synchronous reset to the FSM (high in HOLD)
//   bank_sel       index of the active bank
//   busy           high whenever not IDLE
//   done           one-cycle pulse when a swap completes
//   err_incomplete one-cycle pulse: commit rejected, shadow not fully written
//   err_timeout    one-cycle pulse: commit aborted waiting for a safe point
//   state_dbg      controller state (0 IDLE, 1 WAIT_SAFE, 2 HOLD)
// ---------------------------------------------------------------------------
module fsm_tbl_ctrl #(
  parameter int  STATES  = 16,
  parameter int  ENTRY_W = 32,
  parameter int  TIMEOUT = 255,
  localparam int AW      = $clog2(STATES)
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_tbl_ctrl_if.slave      cfg,
  input  logic               commit,
  input  logic               force_swap,
  input  logic [AW-1:0]      fsm_state,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               fsm_hold,
  output logic               bank_sel,
  output logic               busy,
  output logic               done,
  output logic               err_incomplete,
  output logic               err_timeout,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SAFE = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [ENTRY_W-1:0] bank0 [STATES];
  logic [ENTRY_W-1:0] bank1 [STATES];
  logic [STATES-1:0]  written, written_nx;
  logic [15:0]        wait_cnt, wait_cnt_nx;

  logic wr_en;
  logic commit_req;
  logic swap;
  logic reject;
  logic abort;

  // Next-state and control decode.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    wr_en       = 1'b0;
    commit_req  = 1'b0;
    swap        = 1'b0;
    reject      = 1'b0;
    abort       = 1'b0;
    written_nx  = written;

    case (state)
      IDLE: begin
        wr_en = cfg.cfg_valid;
`ifdef FSM_TBL_CTRL_AUTOCOMMIT_EN
        commit_req = commit | (cfg.cfg_valid & cfg.cfg_last);
`else
        commit_req = commit;
`endif
        // A write accepted in the commit cycle counts toward completeness.
        if (wr_en) written_nx = written | (STATES'(1) << cfg.cfg_addr);
        if (commit_req) begin
          if (&written_nx) begin
            state_nx    = WAIT_SAFE;
            wait_cnt_nx = 16'd0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT_SAFE: begin
        if ((fsm_state == '0) || force_swap) begin
          swap       = 1'b1;
          written_nx = '0;
          state_nx   = HOLD;
        end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
      HOLD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      written        <= '0;
      wait_cnt       <= 16'd0;
      bank_sel       <= 1'b0;
      err_incomplete <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_nx;
      written        <= written_nx;
      wait_cnt       <= wait_cnt_nx;
      err_incomplete <= reject;
      err_timeout    <= abort;
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  // Writes go only to the shadow bank; bank_sel is stable in IDLE, so a
  // write can never race a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATES; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (bank_sel) bank0[cfg.cfg_addr] <= cfg.cfg_data;
      else          bank1[cfg.cfg_addr] <= cfg.cfg_data;
    end
  end

  assign rd_data       = bank_sel ? bank1[rd_addr] : bank0[rd_addr];
  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign fsm_hold      = (state == HOLD);
  assign done          = (state == HOLD);
  assign state_dbg     = state;

endmodule

// File: tb/tb_fsm_tbl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fsm_tbl_ctrl
// Directed bench. dut_a uses the default TIMEOUT; dut_b uses TIMEOUT=8 for
// the abort case. Both share the same stimulus through two interfaces.
// ---------------------------------------------------------------------------
module tb_fsm_tbl_ctrl;

  localparam int STATES  = 16;
  localparam int AW      = 4;
  localparam int ENTRY_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic               cfg_valid = 1'b0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [ENTRY_W-1:0] cfg_data = '0;
  logic               cfg_last = 1'b0;
  logic               commit = 1'b0;
  logic               force_swap = 1'b0;
  logic [AW-1:0]      fsm_state = '0;
  logic [AW-1:0]      rd_addr = '0;

  fsm_tbl_ctrl_if #(.AW(AW), .ENTRY_W(ENTRY_W)) ifa ();
  fsm_tbl_ctrl_if #(.AW(AW), .ENTRY_W(ENTRY_W)) ifb ();

  assign ifa.cfg_valid = cfg_valid;
  assign ifa.cfg_addr  = cfg_addr;
  assign ifa.cfg_data  = cfg_data;
  assign ifb.cfg_valid = cfg_valid;
  assign ifb.cfg_addr  = cfg_addr;
  assign ifb.cfg_data  = cfg_data;
`ifdef FSM_TBL_CTRL_AUTOCOMMIT_EN
  assign ifa.cfg_last  = cfg_last;
  assign ifb.cfg_last  = cfg_last;
`endif

  logic [ENTRY_W-1:0] a_rd_data, b_rd_data;
  logic a_hold, a_bank, a_busy, a_done, a_einc, a_eto;
  logic b_hold, b_bank, b_busy, b_done, b_einc, b_eto;
  logic [1:0] a_state, b_state;

  fsm_tbl_ctrl #(.STATES(STATES), .ENTRY_W(ENTRY_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg(ifa), .commit(commit), .force_swap(force_swap),
    .fsm_state(fsm_state), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .fsm_hold(a_hold), .bank_sel(a_bank), .busy(a_busy), .done(a_done),
    .err_incomplete(a_einc), .err_timeout(a_eto), .state_dbg(a_state)
  );

  fsm_tbl_ctrl #(.STATES(STATES), .ENTRY_W(ENTRY_W), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg(ifb), .commit(commit), .force_swap(force_swap),
    .fsm_state(fsm_state), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .fsm_hold(b_hold), .bank_sel(b_bank), .busy(b_busy), .done(b_done),
    .err_incomplete(b_einc), .err_timeout(b_eto), .state_dbg(b_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [ENTRY_W-1:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_last  = last;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load(input logic [ENTRY_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) wr(AW'(i), base + ENTRY_W'(i), 1'b0);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // ---- reset state ----
    #2;
    for (int i = 0; i < STATES; i++) begin
      rd_addr = AW'(i);
      #1;
      chk("reset_rd_data", a_rd_data, 0);
    end
    chk("reset_bank_sel", a_bank, 0);
    chk("reset_cfg_ready", ifa.cfg_ready, 1);
    chk("reset_busy", a_busy, 0);
    chk("reset_hold", a_hold, 0);
    chk("reset_done", a_done, 0);
    chk("reset_state", a_state, 0);
    step();
    rst_n = 1'b1;
    step();

    // ---- full load, commit with fsm_state=0 ----
    fsm_state = '0;
    load(32'hA000, 16);
    chk("pre_commit_bank", a_bank, 0);
    pulse_commit();
    chk("wait_busy", a_busy, 1);
    chk("wait_bank", a_bank, 0);
    chk("wait_hold", a_hold, 0);
    step();
    chk("swap1_bank", a_bank, 1);
    chk("swap1_hold", a_hold, 1);
    chk("swap1_done", a_done, 1);
    rd_addr = 4'd5;
    #1;
    chk("swap1_rd5", a_rd_data, 32'hA005);
    step();
    chk("swap1_hold_end", a_hold, 0);
    chk("swap1_done_end", a_done, 0);
    chk("swap1_idle", a_busy, 0);

    // ---- incomplete load is rejected ----
    load(32'hB000, 15);
    pulse_commit();
    chk("inc_err", a_einc, 1);
    chk("inc_busy", a_busy, 0);
    chk("inc_bank", a_bank, 1);
    rd_addr = 4'd3;
    #1;
    chk("inc_active_untouched", a_rd_data, 32'hA003);
    step();
    chk("inc_err_end", a_einc, 0);
    wr(4'd15, 32'hB00F, 1'b0);
    pulse_commit();
    chk("inc_fix_busy", a_busy, 1);
    step();
    chk("inc_fix_bank", a_bank, 0);
    chk("inc_fix_done", a_done, 1);
    rd_addr = 4'd15;
    #1;
    chk("inc_fix_rd15", a_rd_data, 32'hB00F);
    rd_addr = 4'd3;
    #1;
    chk("inc_fix_rd3", a_rd_data, 32'hB003);
    step();

    // ---- wait for safe point; writes blocked meanwhile ----
    fsm_state = 4'd3;
    load(32'hC000, 16);
    pulse_commit();
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'b1;
      cfg_addr  = 4'd0;
      cfg_data  = 32'hDEAD;
      #1;
      chk("ws_ready_low", ifa.cfg_ready, 0);
      chk("ws_busy", a_busy, 1);
      chk("ws_bank", a_bank, 0);
      step();
    end
    cfg_valid = 1'b0;
    fsm_state = '0;
    step();
    chk("ws_swap_bank", a_bank, 1);
    chk("ws_swap_hold", a_hold, 1);
    rd_addr = 4'd0;
    #1;
    chk("ws_rd0_no_blocked_write", a_rd_data, 32'hC000);
    rd_addr = 4'd9;
    #1;
    chk("ws_rd9", a_rd_data, 32'hC009);
    step();
    chk("ws_done_end", a_done, 0);

    // ---- reset during WAIT_SAFE ----
    fsm_state = 4'd3;
    load(32'hD000, 16);
    pulse_commit();
    step();
    chk("rst_mid_busy_before", a_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_bank", a_bank, 0);
    chk("rst_mid_ready", ifa.cfg_ready, 1);
    chk("rst_mid_hold", a_hold, 0);
    rd_addr = 4'd7;
    #1;
    chk("rst_mid_rd7", a_rd_data, 0);
    step();
    rst_n = 1'b1;
    step();

    // ---- timeout on dut_b (TIMEOUT=8), then forced swap ----
    fsm_state = 4'd3;
    load(32'hE000, 16);
    pulse_commit();
    for (int i = 0; i < 7; i++) begin
      chk("to_busy", b_busy, 1);
      chk("to_err_early", b_eto, 0);
      step();
    end
    step();
    chk("to_err", b_eto, 1);
    chk("to_busy_end", b_busy, 0);
    chk("to_bank", b_bank, 0);
    step();
    chk("to_err_end", b_eto, 0);
    force_swap = 1'b1;
    pulse_commit();
    chk("force_busy", b_busy, 1);
    step();
    chk("force_bank", b_bank, 1);
    chk("force_done", b_done, 1);
    rd_addr = 4'd4;
    #1;
    chk("force_rd4", b_rd_data, 32'hE004);
    force_swap = 1'b0;
    step();

`ifdef FSM_TBL_CTRL_AUTOCOMMIT_EN
    // ---- autocommit through cfg_last ----
    do_reset();
    fsm_state = '0;
    load(32'hF000, 15);
    wr(4'd15, 32'hF00F, 1'b1);
    chk("auto_busy", a_busy, 1);
    step();
    chk("auto_bank", a_bank, 1);
    chk("auto_done", a_done, 1);
    rd_addr = 4'd15;
    #1;
    chk("auto_rd15", a_rd_data, 32'hF00F);
    step();
    wr(4'd0, 32'h1234, 1'b1);
    chk("auto_inc_err", a_einc, 1);
    chk("auto_inc_busy", a_busy, 0);
    step();
`else
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
